// File: rtl/bash_f_const_inv_if.sv
// Handshake bundle between the inverse round-constant generator and its consumer.
interface bash_f_const_inv_if #(
  parameter int ROUNDS = 24
) ();
  localparam int RW = $clog2(ROUNDS + 1);

  logic          start_i;
  logic [63:0]   seed_i;
  logic          ready_i;
  logic          valid_o;
  logic [63:0]   c_o;
  logic [RW-1:0] round_o;
  logic          last_o;
  logic          busy_o;

  // Consumer / controller side
  modport master (
    output start_i, seed_i, ready_i,
    input  valid_o, c_o, round_o, last_o, busy_o
  );

  // Generator side
  modport slave (
    input  start_i, seed_i, ready_i,
    output valid_o, c_o, round_o, last_o, busy_o
  );
endinterface

// File: rtl/bash_f_const_inv.sv
// Reverse-order bash-f round-constant generator: emits C_N, C_(N-1), ... C_1
// starting from the seed, undoing one forward LFSR step per accepted transfer.
module bash_f_const_inv #(
  parameter int          ROUNDS  = 24,
  parameter logic [63:0] C_CONST = 64'hAED8E07F99E12BDC
) (
  input  logic             clk,
  input  logic             rst,
  bash_f_const_inv_if.slave bus
);
  localparam int RW = $clog2(ROUNDS + 1);

  // Port words are little-endian bytes of the LFSR integer.
  function automatic logic [63:0] bswap(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = w[8*(7-i) +: 8];
    return r;
  endfunction

  localparam logic [63:0] K = bswap(C_CONST);

  // Inverse of I' = (I >> 1) ^ (I[0] ? K : 0); K[63]=1 exposes the shifted-out bit.
  function automatic logic [63:0] inv_step(input logic [63:0] w);
    logic [63:0] i;
    logic [63:0] t;
    logic        b;
    i = bswap(w);
    b = i[63];
    t = i ^ (b ? K : 64'd0);
    return bswap({t[62:0], b});
  endfunction

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [63:0]   c_q;
  logic [RW-1:0] round_q;
  logic          xfer;
  logic          is_last;

  assign xfer    = (state_q == RUN) && bus.ready_i;
  assign is_last = (round_q == RW'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: start only honoured in IDLE; leave RUN on the final transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i)     state_d = RUN;
      RUN:     if (xfer && is_last) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Constant and round counter; both hold while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q     <= '0;
      round_q <= '0;
    end else if (state_q == IDLE && bus.start_i) begin
      c_q     <= bus.seed_i;
      round_q <= RW'(ROUNDS);
    end else if (xfer) begin
      if (is_last) begin
        round_q <= '0;
      end else begin
        c_q     <= inv_step(c_q);
        round_q <= round_q - RW'(1);
      end
    end
  end

  // Outputs decoded from registered state only, so they cannot glitch
  always_comb begin
    bus.valid_o = (state_q == RUN);
    bus.busy_o  = (state_q == RUN);
    bus.last_o  = (state_q == RUN) && is_last;
    bus.c_o     = c_q;
    bus.round_o = round_q;
  end
endmodule

// File: tb/tb_bash_f_const_inv.sv
// Directed bench for bash_f_const_inv with a forward-generator golden model.
module tb_bash_f_const_inv;
  localparam int          ROUNDS = 24;
  localparam int          RW     = $clog2(ROUNDS + 1);
  localparam logic [63:0] K      = 64'hDC2BE1997FE0D8AE;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bash_f_const_inv_if #(.ROUNDS(ROUNDS)) bus ();
  bash_f_const_inv #(.ROUNDS(ROUNDS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bswap(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = w[8*(7-i) +: 8];
    return r;
  endfunction

  // Forward generator step, reference model only
  function automatic logic [63:0] fwd(input logic [63:0] w);
    logic [63:0] i;
    i = bswap(w);
    return bswap((i >> 1) ^ (i[0] ? K : 64'd0));
  endfunction

  logic [63:0]   wc    [ROUNDS];
  logic [RW-1:0] wr    [ROUNDS];
  logic          wl    [ROUNDS];
  logic [63:0]   ref_c [ROUNDS];
  int            n;

  task automatic start_run(input logic [63:0] seed);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.seed_i  = seed;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  // mode 0: ready=1; mode 1: random ready + 5-cycle stall at round 12;
  // mode 2: ready=1 with start pulses mid-run and in the last-transfer cycle
  task automatic collect(input int mode);
    int            cyc;
    bit            stalled;
    logic [63:0]   hc;
    logic [RW-1:0] hr;
    n = 0; cyc = 0; stalled = 0;
    while (n < ROUNDS && cyc < 400) begin
      bus.ready_i = 1'b1;
      if (mode == 1) begin
        if (!stalled && bus.valid_o && bus.round_o == RW'(12)) begin
          stalled     = 1;
          bus.ready_i = 1'b0;
          hc = bus.c_o;
          hr = bus.round_o;
          repeat (5) begin
            @(negedge clk); cyc++;
            chk("stall_valid", 64'(bus.valid_o), 64'd1);
            chk("stall_c", bus.c_o, hc);
            chk("stall_round", 64'(bus.round_o), 64'(hr));
          end
        end
        bus.ready_i = 1'($urandom_range(0, 1));
      end
      if (mode == 2 && bus.valid_o && (bus.round_o == RW'(15) || bus.round_o == RW'(1))) begin
        bus.start_i = 1'b1;
        bus.seed_i  = 64'h0123456789ABCDEF;
      end
      if (bus.valid_o && bus.ready_i) begin
        wc[n] = bus.c_o;
        wr[n] = bus.round_o;
        wl[n] = bus.last_o;
        n++;
      end
      @(negedge clk); cyc++;
      bus.start_i = 1'b0;
    end
    chk("word_count", 64'(n), 64'(ROUNDS));
    bus.ready_i = 1'b1;
  endtask

  task automatic check_run(input logic [63:0] seed);
    chk("first_word", wc[0], seed);
    for (int k = 0; k < ROUNDS; k++) begin
      chk("round_idx", 64'(wr[k]), 64'(ROUNDS - k));
      chk("last_flag", 64'(wl[k]), 64'(k == ROUNDS - 1));
      if (k < ROUNDS - 1) chk("fwd_pair", fwd(wc[k+1]), wc[k]);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 64'(bus.valid_o), 64'd0);
    chk({tag, "_busy"},  64'(bus.busy_o),  64'd0);
    chk({tag, "_last"},  64'(bus.last_o),  64'd0);
  endtask

  logic [63:0] seed_a, seed_b, seed_c;

  initial begin
    rst = 1'b1; bus.start_i = 1'b0; bus.seed_i = '0; bus.ready_i = 1'b1;
    #12;
    check_idle("reset");
    chk("reset_c", bus.c_o, 64'd0);
    chk("reset_round", 64'(bus.round_o), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // Single step: seed equal to C maps to integer K, inverse gives integer 1
    start_run(64'hAED8E07F99E12BDC);
    chk("t1_valid_latency", 64'(bus.valid_o), 64'd1);
    collect(0);
    check_run(64'hAED8E07F99E12BDC);
    chk("t1_word1", wc[1], 64'h0100000000000000);
    chk("t1_round0", 64'(wr[0]), 64'd24);
    chk("t1_round1", 64'(wr[1]), 64'd23);
    check_idle("t1_end");

    // Zero-feedback steps are plain left shifts of the integer
    start_run(64'h0200000000000000);
    collect(0);
    chk("t2_word1", wc[1], 64'h0400000000000000);
    chk("t2_word2", wc[2], 64'h0800000000000000);

    // Full random round-trip, kept as reference sequence
    seed_a = {$urandom, $urandom};
    start_run(seed_a);
    collect(0);
    check_run(seed_a);
    for (int k = 0; k < ROUNDS; k++) ref_c[k] = wc[k];

    // Backpressure must not change the sequence
    start_run(seed_a);
    collect(1);
    check_run(seed_a);
    for (int k = 0; k < ROUNDS; k++) chk("bp_same_seq", wc[k], ref_c[k]);

    // Starts while busy, including in the last-transfer cycle, are ignored
    start_run(seed_a);
    collect(2);
    for (int k = 0; k < ROUNDS; k++) chk("sb_same_seq", wc[k], ref_c[k]);
    repeat (3) begin
      check_idle("sb_after");
      @(negedge clk);
    end

    // Asynchronous reset mid-run
    seed_b = {$urandom, $urandom};
    start_run(seed_b);
    begin
      int w;
      w = 0;
      while (bus.round_o != RW'(10) && w < 60) begin @(negedge clk); w++; end
      chk("reach_round10", 64'(bus.round_o), 64'd10);
    end
    #3 rst = 1'b1;
    #1;
    check_idle("mid_rst");
    chk("mid_rst_c", bus.c_o, 64'd0);
    chk("mid_rst_round", 64'(bus.round_o), 64'd0);
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check_idle("rst_release");
    @(negedge clk);
    check_idle("rst_release2");
    seed_c = {$urandom, $urandom};
    start_run(seed_c);
    collect(0);
    check_run(seed_c);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bash_f_const_inv.md
Name: bash_f_const_inv

Overview:
- Reverse-order round-constant generator for inverse bash-f (decryption-side / unwind permutation).
- Takes the last round constant as a seed and emits ROUNDS constants C_N, C_(N-1), ..., one per accepted handshake.
- Each step undoes exactly one step of the forward constant update.
- Sits beside the inverse bash-f round datapath and feeds it one constant per round.

Parameters:
- ROUNDS, 24, number of constants emitted per run (>=2).
- C_CONST, 64'hAED8E07F99E12BDC, feedback constant in port byte order; same value as the forward generator.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_i  input  1  start pulse; accepted only in IDLE.
- seed_i  input  64  first constant to emit (port byte order); sampled with an accepted start_i.
- ready_i  input  1  consumer ready.
- valid_o  output  1  c_o holds a valid constant.
- c_o  output  64  current constant (port byte order).
- round_o  output  $clog2(ROUNDS+1)  index of c_o; counts ROUNDS down to 1.
- last_o  output  1  c_o is the final constant of the run; round_o==1.
- busy_o  output  1  run in progress, state RUN.

Behaviour:
- Byte order:
  - Port word W maps to integer I = byte-reverse(W), where byte 0 of W, W[7:0], is the most significant byte of I.
  - I[63] = W[7] and I[0] = W[56].
  - K = byte-reverse(C_CONST) = 64'hDC2BE1997FE0D8AE; K[63] = 1.
- Forward step (reference only, not implemented here): I' = (I >> 1) ^ (I[0] ? K : 0).
- Inverse step (implemented, purely combinational inside the block):
  - b = I'[63].
  - t = I' ^ (b ? K : 0).
  - I = {t[62:0], b}.
  - Result is re-byte-reversed to port order.
- FSM has two states, IDLE and RUN.
- IDLE:
  - valid_o=0, busy_o=0, last_o=0.
  - start_i=1 causes c_reg <= seed_i, round <= ROUNDS, and a transition to RUN on the next edge.
  - valid_o=1 from the first cycle in RUN, so start-to-valid latency is 1 cycle.
- RUN:
  - valid_o=1 and busy_o=1; c_o=c_reg.
  - A transfer occurs when valid_o & ready_i.
  - On a transfer with round_o>1: c_reg <= inv_step(c_reg), round <= round-1. The new word is visible the next cycle.
  - On a transfer with round_o==1 (last_o=1): return to IDLE; valid_o deasserts the next cycle.
  - When ready_i=0: c_o, round_o and last_o hold stable, and valid_o stays high (no retraction).
  - start_i is ignored while in RUN.
- A start_i arriving in the cycle of the last transfer is ignored. A new start needs IDLE, so the minimum gap is 1 idle cycle between runs.
- last_o = busy_o & (round_o==1), registered-equivalent and glitch-free from state.
- Reset (asynchronous, any time, including mid-run):
  - State goes to IDLE.
  - valid_o=0, busy_o=0, last_o=0, c_o=0, round_o=0.
  - The run is abandoned with no partial output after release.
- Invariant: for consecutive emitted words A then B, forward_step(B)==A.
- Exactly ROUNDS transfers occur per run.

Test Plan:
- Single step:
  - Stimulus: seed_i=64'hAED8E07F99E12BDC, ready_i=1, start.
  - Required response: c_o=64'hAED8E07F99E12BDC at round 24, then c_o=64'h0100000000000000 at round 23.
- Zero-feedback step:
  - Stimulus: seed_i=64'h0200000000000000.
  - Required response: second word 64'h0400000000000000, third word 64'h0800000000000000.
- Full run round-trip:
  - Stimulus: random seed, ready_i=1.
  - Required responses:
    - Exactly 24 valid cycles, round_o 24..1.
    - last_o only on the 24th.
    - Every adjacent pair satisfies forward_step(next)==prev, checked against a golden model of the forward generator.
- Backpressure:
  - Stimulus: ready_i toggles randomly, plus a 5-cycle stall on round 12.
  - Required response: c_o and round_o are stable during the stall, valid_o stays 1, and the sequence is identical to the ready_i=1 run.
- Start while busy:
  - Stimulus: pulse start_i with a different seed mid-run, and again in the last-transfer cycle.
  - Required response: both ignored, and the sequence is unchanged.
- Reset mid-run:
  - Stimulus: assert rst asynchronously at round 10 (not clock-aligned).
  - Required responses:
    - Outputs go to 0 immediately.
    - After release, IDLE.
    - A fresh start produces a full 24-word run from the new seed.
